// File: rtl/pingpong_pkg.sv
// Shared constants for the ping-pong read controller: bank encoding and output buffer sizing.
// Used by pingpong_read_ctrl and pingpong_obuf.
package pingpong_pkg;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  localparam int OBUF_DEPTH = 2;
  localparam int OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int OBUF_PTR_W = $clog2(OBUF_DEPTH);

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/pingpong_read_ctrl_if.sv
// Bank FIFO read port plus downstream valid/ready stream of the ping-pong read controller.
// The ctrl modport is the controller's view; the env modport is the FIFOs/consumer side.
interface pingpong_read_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic             empty0;
  logic             empty1;
  logic [WIDTH-1:0] data_out0;
  logic [WIDTH-1:0] data_out1;
  logic             renq0;
  logic             renq1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_bank;
  logic [CNT_W-1:0] rd_count;
  logic             err_o;

  modport ctrl (
    input  empty0, empty1, data_out0, data_out1, out_ready,
    output renq0, renq1, out_valid, out_data, out_bank, rd_count, err_o
  );

  modport env (
    output empty0, empty1, data_out0, data_out1, out_ready,
    input  renq0, renq1, out_valid, out_data, out_bank, rd_count, err_o
  );

endinterface

// File: rtl/pingpong_obuf.sv
// Two-entry output FIFO holding {bank, data} words between the bank FIFOs and the consumer.
// The caller guarantees no push when full unless a pop happens in the same cycle.
module pingpong_obuf
  import pingpong_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [OBUF_CNT_W-1:0] count
);

  localparam logic [OBUF_CNT_W-1:0] FULL = OBUF_CNT_W'(OBUF_DEPTH);

  logic [DW-1:0]         mem_q [OBUF_DEPTH];
  logic [DW-1:0]         mem_d [OBUF_DEPTH];
  logic [OBUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OBUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OBUF_CNT_W-1:0] count_q, count_d;
  logic                  push;
  logic                  pop;

  always_comb begin
    pop      = (count_q != '0) && out_ready;
    push     = in_valid && ((count_q != FULL) || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/pingpong_read_ctrl.sv
// Read side of a ping-pong FIFO pair: pops banks strictly 0,1,0,1 into a 2-entry output buffer.
// Optional bank-order stall detector enabled by defining PINGPONG_RD_ERR_EN.
module pingpong_read_ctrl
  import pingpong_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 16,
  parameter int ERR_TIMEOUT = 64
) (
  input logic                 rclk,
  input logic                 reset_n,
  pingpong_read_ctrl_if.ctrl  bus
);

  bank_e                 rfp_q, rfp_d;
  logic                  inflight_q, inflight_d;
  bank_e                 inflight_bank_q, inflight_bank_d;
  logic [CNT_W-1:0]      rd_count_q, rd_count_d;

  logic [OBUF_CNT_W-1:0] ob_count;
  logic                  ob_valid;
  logic [WIDTH:0]        ob_head;
  logic [WIDTH:0]        ob_wdata;

  logic [2:0]            occ;
  logic [2:0]            occ_after_pop;
  logic                  pop;
  logic                  rfp_empty;
  logic                  other_empty;
  logic                  renq;

  always_comb begin
    rfp_empty     = (rfp_q == BANK1) ? bus.empty1 : bus.empty0;
    other_empty   = (rfp_q == BANK1) ? bus.empty0 : bus.empty1;
    pop           = ob_valid && bus.out_ready;
    occ           = 3'(ob_count) + 3'(inflight_q);
    occ_after_pop = occ - 3'(pop);
    // Gated by reset_n so nothing is popped while reset is held.
    renq          = reset_n && !rfp_empty && (occ_after_pop < 3'(OBUF_DEPTH));

    rfp_d           = renq ? other_bank(rfp_q) : rfp_q;
    inflight_d      = renq;
    inflight_bank_d = rfp_q;
    rd_count_d      = pop ? rd_count_q + 1'b1 : rd_count_q;
    ob_wdata        = {inflight_bank_q,
                       (inflight_bank_q == BANK1) ? bus.data_out1 : bus.data_out0};
  end

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      rfp_q           <= BANK0;
      inflight_q      <= 1'b0;
      inflight_bank_q <= BANK0;
      rd_count_q      <= '0;
    end else begin
      rfp_q           <= rfp_d;
      inflight_q      <= inflight_d;
      inflight_bank_q <= inflight_bank_d;
      rd_count_q      <= rd_count_d;
    end
  end

  pingpong_obuf #(
    .DW (WIDTH + 1)
  ) u_obuf (
    .clk       (rclk),
    .rst_n     (reset_n),
    .in_valid  (inflight_q),
    .in_data   (ob_wdata),
    .out_valid (ob_valid),
    .out_ready (bus.out_ready),
    .out_data  (ob_head),
    .count     (ob_count)
  );

  assign bus.renq0     = renq && (rfp_q == BANK0);
  assign bus.renq1     = renq && (rfp_q == BANK1);
  assign bus.out_valid = ob_valid;
  assign bus.out_data  = ob_head[WIDTH-1:0];
  assign bus.out_bank  = ob_head[WIDTH];
  assign bus.rd_count  = rd_count_q;

`ifdef PINGPONG_RD_ERR_EN
  localparam int ERR_CNT_W = $clog2(ERR_TIMEOUT + 1);
  localparam logic [ERR_CNT_W-1:0] ERR_LIMIT = ERR_CNT_W'(ERR_TIMEOUT);

  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_q, err_d;
  logic                 order_stall;

  always_comb begin
    // The writer filled the wrong bank ahead of the one we are waiting on.
    order_stall = rfp_empty && !other_empty;
    err_cnt_d   = '0;
    if (order_stall) begin
      err_cnt_d = (err_cnt_q == ERR_LIMIT) ? err_cnt_q : err_cnt_q + 1'b1;
    end
    err_d = err_q || (order_stall && (err_cnt_d == ERR_LIMIT));
  end

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_read_ctrl.sv
// Directed bench for pingpong_read_ctrl with queue-modelled bank FIFOs (1-cycle read latency).
// Error expectations follow PINGPONG_RD_ERR_EN; the DUT is built with ERR_TIMEOUT=4.
module tb_pingpong_read_ctrl;
  import pingpong_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
`ifdef PINGPONG_RD_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic rclk;
  logic reset_n;

  pingpong_read_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pingpong_read_ctrl #(
    .WIDTH       (WIDTH),
    .CNT_W       (CNT_W),
    .ERR_TIMEOUT (4)
  ) dut (
    .rclk    (rclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks;
  int failures;
  int cyc;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] got_data[$];
  logic             got_bank[$];
  int               got_cyc[$];
  logic             last_renq0;
  logic             last_renq1;
  logic             last_pop;

  task automatic update_empty();
    bus.empty0 = (q0.size() == 0);
    bus.empty1 = (q1.size() == 0);
  endtask

  task automatic clear_got();
    got_data.delete();
    got_bank.delete();
    got_cyc.delete();
  endtask

  // One clock cycle: sample the cycle's handshakes at negedge, then model FIFO pops after the edge.
  task automatic tick();
    @(negedge rclk);
    last_renq0 = bus.renq0;
    last_renq1 = bus.renq1;
    last_pop   = bus.out_valid & bus.out_ready;
    if (last_pop) begin
      got_data.push_back(bus.out_data);
      got_bank.push_back(bus.out_bank);
      got_cyc.push_back(cyc);
      $display("cycle %0d: pop data=%02h bank=%0d", cyc, bus.out_data, bus.out_bank);
    end
    @(posedge rclk);
    #1;
    cyc++;
    if (last_renq0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL renq0_underflow: renq0=1 while bank0 empty (required 0)");
      end else begin
        bus.data_out0 = q0.pop_front();
      end
    end
    if (last_renq1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL renq1_underflow: renq1=1 while bank1 empty (required 0)");
      end else begin
        bus.data_out1 = q1.pop_front();
      end
    end
    update_empty();
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.out_ready = 1'b0;
    q0.delete();
    q1.delete();
    update_empty();
    tick();
    tick();
    reset_n = 1'b1;
    clear_got();
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.out_ready = 1'b1;
    q0.push_back(8'h10);
    q1.push_back(8'h20);
    update_empty();
    tick();
    tick();
    checks++;
    if (last_renq0 !== 1'b0 || last_renq1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_renq: renq0=%b renq1=%b required 0 0", last_renq0, last_renq1);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
    end
    checks++;
    if (bus.rd_count !== '0) begin
      failures++;
      $display("FAIL reset_rd_count: got %0d required 0", bus.rd_count);
    end
    checks++;
    if (bus.out_data !== '0 || bus.out_bank !== 1'b0 || bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: data=%02h bank=%b err=%b required 00 0 0",
               bus.out_data, bus.out_bank, bus.err_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] exp_d[4];
    logic             exp_b[4];
    exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    q0.push_back(8'hA0); q0.push_back(8'hA1);
    q1.push_back(8'hB0); q1.push_back(8'hB1);
    update_empty();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (got_data.size() != 4) begin
      failures++;
      $display("FAIL stream_count: got %0d words required 4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] !== exp_d[i] || got_bank[i] !== exp_b[i] || got_cyc[i] != got_cyc[0] + i) begin
          failures++;
          $display("FAIL stream_word%0d: data=%02h bank=%b cyc=+%0d required %02h %b +%0d",
                   i, got_data[i], got_bank[i], got_cyc[i] - got_cyc[0], exp_d[i], exp_b[i], i);
        end
      end
    end
    checks++;
    if (bus.rd_count !== 16'd4) begin
      failures++;
      $display("FAIL stream_rd_count: got %0d required 4", bus.rd_count);
    end
    $display("test_streaming done");
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp_d[8];
    logic [WIDTH-1:0] held;
    int               pulses;
    int               unstable;
    logic             seen;
    exp_d = '{8'h30, 8'h40, 8'h31, 8'h41, 8'h32, 8'h42, 8'h33, 8'h43};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'h30 + 8'(i));
      q1.push_back(8'h40 + 8'(i));
    end
    update_empty();
    pulses   = 0;
    unstable = 0;
    seen     = 1'b0;
    held     = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_renq0 || last_renq1) pulses++;
      if (bus.out_valid) begin
        if (!seen) begin
          held = bus.out_data;
          seen = 1'b1;
        end else if (bus.out_data !== held) begin
          unstable++;
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL bp_renq_pulses: got %0d required 2", pulses);
    end
    checks++;
    if (unstable != 0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h30) begin
      failures++;
      $display("FAIL bp_hold: valid=%b data=%02h changes=%0d required 1 30 0",
               bus.out_valid, bus.out_data, unstable);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (got_data.size() != 8) begin
      failures++;
      $display("FAIL bp_count: got %0d words required 8", got_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_data[i] !== exp_d[i] || got_cyc[i] != got_cyc[0] + i) begin
          failures++;
          $display("FAIL bp_word%0d: data=%02h cyc=+%0d required %02h +%0d",
                   i, got_data[i], got_cyc[i] - got_cyc[0], exp_d[i], i);
        end
      end
    end
    checks++;
    if (bus.rd_count !== 16'd8) begin
      failures++;
      $display("FAIL bp_rd_count: got %0d required 8", bus.rd_count);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_bank_stall();
    int stray;
    do_reset();
    q0.push_back(8'h50);
    q1.push_back(8'h60);
    update_empty();
    for (int i = 0; i < 3; i++) tick();
    // Pointer is back on bank 0, which is empty, while bank 1 gets data.
    q1.push_back(8'h61);
    update_empty();
    bus.out_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_renq0 || last_renq1) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL stall_no_renq: got %0d pulses required 0", stray);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || got_data.size() != 2) begin
      failures++;
      $display("FAIL stall_drain: valid=%b words=%0d required 0 2", bus.out_valid, got_data.size());
    end
    q0.push_back(8'h51);
    update_empty();
    tick();
    checks++;
    if (last_renq0 !== 1'b1 || last_renq1 !== 1'b0) begin
      failures++;
      $display("FAIL stall_resume: renq0=%b renq1=%b required 1 0", last_renq0, last_renq1);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (got_data.size() != 4 || got_data[2] !== 8'h51 || got_data[3] !== 8'h61) begin
      failures++;
      $display("FAIL stall_order: words=%0d third/fourth=%02h %02h required 4 51 61", got_data.size(),
               (got_data.size() > 2) ? got_data[2] : 8'hxx, (got_data.size() > 3) ? got_data[3] : 8'hxx);
    end
    $display("test_bank_stall done");
  endtask

  task automatic test_error();
    do_reset();
    q1.push_back(8'h70);
    update_empty();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_early: got %b required 0 after 3 stall cycles", bus.err_o);
    end
    tick();
    checks++;
    if (bus.err_o !== ERR_EN) begin
      failures++;
      $display("FAIL err_set: got %b required %b after 4 stall cycles", bus.err_o, ERR_EN);
    end
    q0.push_back(8'h71);
    update_empty();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.err_o !== ERR_EN || got_data.size() != 2) begin
      failures++;
      $display("FAIL err_sticky: err=%b words=%0d required %b 2", bus.err_o, got_data.size(), ERR_EN);
    end
    $display("test_error done");
  endtask

  task automatic test_midreset();
    do_reset();
    q0.push_back(8'h80); q0.push_back(8'h81);
    q1.push_back(8'h90); q1.push_back(8'h91);
    update_empty();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h80) begin
      failures++;
      $display("FAIL mid_prefill: valid=%b data=%02h required 1 80", bus.out_valid, bus.out_data);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.rd_count !== '0) begin
      failures++;
      $display("FAIL mid_async_clear: valid=%b data=%02h count=%0d required 0 00 0",
               bus.out_valid, bus.out_data, bus.rd_count);
    end
    tick();
    checks++;
    if (last_renq0 !== 1'b0 || last_renq1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_renq: renq0=%b renq1=%b required 0 0", last_renq0, last_renq1);
    end
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    clear_got();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (got_data.size() != 2 || got_data[0] !== 8'h81 || got_bank[0] !== 1'b0 || got_data[1] !== 8'h91) begin
      failures++;
      $display("FAIL mid_restart: words=%0d first=%02h bank=%b required 2 81 0", got_data.size(),
               (got_data.size() > 0) ? got_data[0] : 8'hxx, (got_bank.size() > 0) ? got_bank[0] : 1'bx);
    end
    $display("test_midreset done");
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    reset_n       = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_out0 = '0;
    bus.data_out1 = '0;
    update_empty();
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bank_stall();
    test_error();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
